// File: rtl/quad_cmd_pkg.sv
// Shared opcodes, response codes, sequencer state and debug view.
package quad_cmd_pkg;

    localparam logic [7:0] SET_PITCH  = 8'h02;
    localparam logic [7:0] SET_ROLL   = 8'h03;
    localparam logic [7:0] SET_YAW    = 8'h04;
    localparam logic [7:0] SET_THRST  = 8'h05;
    localparam logic [7:0] CALIBRATE  = 8'h06;
    localparam logic [7:0] EMER_LAND  = 8'h07;
    localparam logic [7:0] MOTORS_OFF = 8'h08;

    localparam logic [7:0] POS_ACK    = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_RESP,
        ST_CLR,
        ST_RETIRE
    } seq_state_t;

    // Debug view of the sequencer for checkers and waveform reading.
    typedef struct packed {
        seq_state_t state;
        logic       sent_seen;  // cmd_sent observed during the current attempt
        logic [7:0] retry;
    } seq_dbg_t;

    // Attempts made = retries + 1, saturating at 3 to fit the status field.
    function automatic logic [1:0] sat_tries(input logic [7:0] retry);
        if (retry >= 8'd2) return 2'd3;
        else               return retry[1:0] + 2'd1;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO holding queued commands. A push and a pop in the same
// cycle are both honoured, even when full. flush_i empties it and drops any
// push in that cycle.
module cmd_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             ovf_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && !flush_i && (!full_o || do_pop);
    assign ovf_o   = push_i && !flush_i && full_o && !do_pop;
    assign dout_o  = mem_q[rd_ptr_q];

    // Storage array: written on an accepted push, no reset needed.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/remote_cmd_sequencer.sv
// Sequences queued host commands through the RemoteComm send/response
// handshake, retrying on NAK or timeout and reporting per-command status.
// Handshake: send_cmd is a one-cycle strobe with cmd/data held for the whole
// attempt; resp_rdy stays high until acknowledged by a one-cycle clr_resp_rdy.
module remote_cmd_sequencer
    import quad_cmd_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int RESP_TIMEOUT = 1000000,
    parameter int CAL_TIMEOUT  = 4000000,
    parameter int MAX_RETRY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [7:0]  push_cmd,
    input  logic [15:0] push_data,
    output logic        full,
    output logic        ovf,
    input  logic        abort,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        send_cmd,
    input  logic        cmd_sent,
    input  logic        resp_rdy,
    input  logic [7:0]  resp,
    output logic        clr_resp_rdy,
    output logic        busy,
    output logic        done,
    output logic        done_ok,
    output logic [7:0]  done_resp,
    output logic [1:0]  done_tries,
    output seq_dbg_t    dbg
);
    seq_state_t  state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] data_q, data_d;
    logic [31:0] timer_q, timer_d;
    logic [7:0]  retry_q, retry_d;
    logic [7:0]  done_resp_q, done_resp_d;
    logic        done_ok_q, done_ok_d;
    logic [1:0]  done_tries_q, done_tries_d;
    logic        sent_seen_q, sent_seen_d;

    logic [23:0] head;
    logic        fifo_empty;
    logic        fifo_pop;
    logic        fail;

    cmd_fifo #(
        .WIDTH(24),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i  (clk),
        .rst_i  (rst),
        .flush_i(abort),
        .push_i (push),
        .din_i  ({push_cmd, push_data}),
        .pop_i  (fifo_pop),
        .dout_o (head),
        .full_o (full),
        .empty_o(fifo_empty),
        .ovf_o  (ovf)
    );

    assign cmd        = cmd_q;
    assign data       = data_q;
    assign busy       = (state_q != ST_IDLE);
    assign done_ok    = done_ok_q;
    assign done_resp  = done_resp_q;
    assign done_tries = done_tries_q;
    assign dbg        = '{state: state_q, sent_seen: sent_seen_q, retry: retry_q};

    // Next-state, strobes and retry decision; abort overrides everything.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        data_d       = data_q;
        timer_d      = timer_q;
        retry_d      = retry_q;
        done_resp_d  = done_resp_q;
        done_ok_d    = done_ok_q;
        done_tries_d = done_tries_q;
        sent_seen_d  = sent_seen_q;
        fifo_pop     = 1'b0;
        send_cmd     = 1'b0;
        clr_resp_rdy = 1'b0;
        done         = 1'b0;
        fail         = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Drain any stale response left over from an aborted command.
                    clr_resp_rdy = resp_rdy;
                    if (!fifo_empty) begin
                        cmd_d   = head[23:16];
                        data_d  = head[15:0];
                        retry_d = '0;
                        state_d = ST_SEND;
                    end
                end
                ST_SEND: begin
                    send_cmd    = 1'b1;
                    timer_d     = (cmd_q == CALIBRATE) ? 32'(CAL_TIMEOUT) : 32'(RESP_TIMEOUT);
                    sent_seen_d = 1'b0;
                    state_d     = ST_WAIT_RESP;
                end
                ST_WAIT_RESP: begin
                    timer_d = timer_q - 32'd1;
                    if (cmd_sent) sent_seen_d = 1'b1;
                    // A response on the final timer cycle still counts.
                    if (resp_rdy) begin
                        done_resp_d = resp;
                        state_d     = ST_CLR;
                    end else if (timer_q <= 32'd1) begin
                        done_resp_d = 8'h00;
                        fail        = 1'b1;
                    end
                end
                ST_CLR: begin
                    clr_resp_rdy = 1'b1;
                    if (done_resp_q == POS_ACK) begin
                        done_ok_d    = 1'b1;
                        done_tries_d = sat_tries(retry_q);
                        state_d      = ST_RETIRE;
                    end else begin
                        fail = 1'b1;
                    end
                end
                ST_RETIRE: begin
                    done     = 1'b1;
                    fifo_pop = 1'b1;
                    state_d  = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase

            if (fail) begin
                if (retry_q < 8'(MAX_RETRY)) begin
                    retry_d = retry_q + 8'd1;
                    state_d = ST_SEND;
                end else begin
                    done_ok_d    = 1'b0;
                    done_tries_d = sat_tries(retry_q);
                    state_d      = ST_RETIRE;
                end
            end
        end
    end

    // State, latched command, timer, retry count and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            data_q       <= '0;
            timer_q      <= '0;
            retry_q      <= '0;
            done_resp_q  <= '0;
            done_ok_q    <= 1'b0;
            done_tries_q <= '0;
            sent_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            data_q       <= data_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            done_resp_q  <= done_resp_d;
            done_ok_q    <= done_ok_d;
            done_tries_q <= done_tries_d;
            sent_seen_q  <= sent_seen_d;
        end
    end

endmodule

// File: tb/tb_remote_cmd_sequencer.sv
// Bench for remote_cmd_sequencer: table of command scenarios against a
// scripted RemoteComm responder, plus overflow and abort sequences.
module tb_remote_cmd_sequencer;
    import quad_cmd_pkg::*;

    localparam int RT = 50;
    localparam int CT = 200;

    logic        clk, rst;
    logic        push, abort, cmd_sent, resp_rdy;
    logic [7:0]  push_cmd, resp;
    logic [15:0] push_data;
    logic        full, ovf, send_cmd, clr_resp_rdy, busy, done, done_ok;
    logic [7:0]  cmd, done_resp;
    logic [15:0] data;
    logic [1:0]  done_tries;
    seq_dbg_t    dbg;

    remote_cmd_sequencer #(
        .DEPTH(4), .RESP_TIMEOUT(RT), .CAL_TIMEOUT(CT), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .rst(rst), .push(push), .push_cmd(push_cmd), .push_data(push_data),
        .full(full), .ovf(ovf), .abort(abort), .cmd(cmd), .data(data),
        .send_cmd(send_cmd), .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp),
        .clr_resp_rdy(clr_resp_rdy), .busy(busy), .done(done), .done_ok(done_ok),
        .done_resp(done_resp), .done_tries(done_tries), .dbg(dbg)
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- counters / checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- RemoteComm model ----------------
    typedef struct {
        logic [7:0] resp;   // 0 = never respond (timeout)
        int         delay;  // cycles after the send_cmd cycle
    } rsp_t;
    rsp_t script_q[$];

    initial begin
        rsp_t e;
        int   k;
        resp_rdy = 1'b0;
        resp     = 8'h00;
        forever begin
            @(negedge clk);
            if (send_cmd) begin
                if (script_q.size() > 0) e = script_q.pop_front();
                else e = '{resp: 8'h00, delay: 0};
                if (e.resp != 8'h00) begin
                    repeat (e.delay) @(posedge clk);
                    #1;
                    resp_rdy = 1'b1;
                    resp     = e.resp;
                    k = 0;
                    do begin @(negedge clk); k++; end while (!clr_resp_rdy && k < 40);
                    check("clr_ack", 64'(clr_resp_rdy), 64'd1);
                    @(posedge clk);
                    #1;
                    resp_rdy = 1'b0;
                    resp     = 8'h00;
                end
            end
        end
    end

    initial begin
        logic p;
        cmd_sent = 1'b0;
        forever begin
            @(negedge clk);
            p = send_cmd;
            @(posedge clk);
            #1 cmd_sent = p;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [34:0] exp_q[$];  // {cmd, data, ok, tries, resp}
    int send_cnt = 0, clr_cnt = 0, done_cnt = 0, ovf_cnt = 0;
    int last_send_cyc = 0, last_clr_cyc = 0, last_done_cyc = 0, last_rdy_cyc = 0;
    int gap_base = 0, gap_min = 0, gap_max = 0;

    initial begin
        logic        rdy_prev;
        logic [34:0] got, want;
        int          g;
        rdy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (send_cmd) begin
                    if (send_cnt > gap_base) begin
                        g = cyc - last_send_cyc;
                        if (g < gap_min) gap_min = g;
                        if (g > gap_max) gap_max = g;
                    end
                    last_send_cyc = cyc;
                    send_cnt++;
                end
                if (clr_resp_rdy) begin clr_cnt++; last_clr_cyc = cyc; end
                if (resp_rdy && !rdy_prev) last_rdy_cyc = cyc;
                rdy_prev = resp_rdy;
                if (ovf) ovf_cnt++;
                if (done) begin
                    done_cnt++;
                    last_done_cyc = cyc;
                    got = {cmd, data, done_ok, done_tries, done_resp};
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 64'(got), 64'd0);
                    end else begin
                        want = exp_q.pop_front();
                        check("done_record", 64'(got), 64'(want));
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_push(input logic [7:0] c, input logic [15:0] d);
        @(posedge clk);
        #1;
        push      = 1'b1;
        push_cmd  = c;
        push_data = d;
    endtask

    task automatic drive_idle();
        @(posedge clk);
        #1;
        push  = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_dones(input int target, input int budget);
        int k;
        k = 0;
        while (done_cnt < target && k < budget) begin @(negedge clk); k++; end
        check("done_count", 64'(done_cnt), 64'(target));
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] data;
        int          naks;
        logic [7:0]  final_resp;
        int          delay;
        logic        exp_ok;
        logic [1:0]  exp_tries;
        logic [7:0]  exp_resp;
        int          exp_sends;
    } vec_t;

    vec_t vecs[8];

    // ---------------- test ----------------
    initial begin
        int s0, d0, c0, o0;
        rst = 1'b1; push = 1'b0; abort = 1'b0; push_cmd = 8'h00; push_data = 16'h0000;

        vecs[0] = '{SET_PITCH,  16'h0040, 0, 8'hA5, 4,   1'b1, 2'd1, 8'hA5, 1};
        vecs[1] = '{SET_ROLL,   16'h1234, 2, 8'hA5, 6,   1'b1, 2'd3, 8'hA5, 3};
        vecs[2] = '{SET_YAW,    16'hFFFF, 0, 8'h00, 0,   1'b0, 2'd3, 8'h00, 3};
        vecs[3] = '{SET_THRST,  16'h0BAD, 3, 8'h00, 5,   1'b0, 2'd3, 8'hFF, 3};
        vecs[4] = '{CALIBRATE,  16'h0000, 0, 8'hA5, 150, 1'b1, 2'd1, 8'hA5, 1};
        vecs[5] = '{EMER_LAND,  16'h0000, 0, 8'hA5, RT,  1'b1, 2'd1, 8'hA5, 1};
        vecs[6] = '{MOTORS_OFF, 16'h0000, 1, 8'hA5, 2,   1'b1, 2'd2, 8'hA5, 2};
        vecs[7] = '{SET_ROLL,   16'h8001, 1, 8'h00, 3,   1'b0, 2'd3, 8'h00, 3};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_strobes", 64'({send_cmd, clr_resp_rdy, busy, done, done_ok, full, ovf}), 64'd0);
        check("rst_status", 64'({done_resp, done_tries}), 64'd0);
        check("rst_cmd_data", 64'({cmd, data}), 64'd0);
        check("rst_state", 64'(dbg.state), 64'(ST_IDLE));
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_after_rst", 64'({busy, send_cmd, clr_resp_rdy, done, full}), 64'd0);

        // Table-driven command scenarios.
        for (int i = 0; i < 8; i++) begin
            script_q.delete();
            for (int a = 0; a < 3; a++) begin
                if (a < vecs[i].naks) script_q.push_back('{resp: 8'hFF, delay: vecs[i].delay});
                else script_q.push_back('{resp: vecs[i].final_resp, delay: vecs[i].delay});
            end
            exp_q.push_back({vecs[i].cmd, vecs[i].data, vecs[i].exp_ok, vecs[i].exp_tries, vecs[i].exp_resp});
            s0 = send_cnt; d0 = done_cnt;
            gap_base = send_cnt; gap_min = 1 << 30; gap_max = 0;
            drive_push(vecs[i].cmd, vecs[i].data);
            drive_idle();
            @(negedge clk);
            @(negedge clk);
            check($sformatf("v%0d_send_latency", i), 64'(send_cmd), 64'd1);
            check($sformatf("v%0d_cmd_data", i), 64'({cmd, data}), 64'({vecs[i].cmd, vecs[i].data}));
            wait_dones(d0 + 1, 1000);
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_sends", i), 64'(send_cnt - s0), 64'(vecs[i].exp_sends));
            check($sformatf("v%0d_busy_end", i), 64'(busy), 64'd0);
            if (vecs[i].exp_ok) begin
                check($sformatf("v%0d_clr_timing", i), 64'(last_clr_cyc - last_rdy_cyc), 64'd1);
                check($sformatf("v%0d_done_timing", i), 64'(last_done_cyc - last_rdy_cyc), 64'd2);
            end
            if (vecs[i].naks == 0 && vecs[i].final_resp == 8'h00) begin
                check("timeout_gap_min", 64'(gap_min >= RT && gap_min <= RT + 1), 64'd1);
                check("timeout_gap_max", 64'(gap_max >= RT && gap_max <= RT + 1), 64'd1);
            end
        end

        // Overflow: 5 back-to-back pushes into a 4-deep queue.
        script_q.delete();
        for (int a = 0; a < 4; a++) begin
            script_q.push_back('{resp: 8'hA5, delay: 3});
            exp_q.push_back({SET_PITCH, 16'(16'h0100 + a), 1'b1, 2'd1, 8'hA5});
        end
        d0 = done_cnt; o0 = ovf_cnt;
        for (int a = 0; a < 5; a++) begin
            drive_push(SET_PITCH, 16'(16'h0100 + a));
            @(negedge clk);
            if (a == 4) begin
                check("ovf_full", 64'(full), 64'd1);
                check("ovf_pulse", 64'(ovf), 64'd1);
            end
        end
        drive_idle();
        wait_dones(d0 + 4, 500);
        repeat (3) @(negedge clk);
        check("ovf_count", 64'(ovf_cnt - o0), 64'd1);
        check("ovf_queue_drained", 64'({full, busy}), 64'd0);

        // Abort while waiting for a response with two entries queued.
        script_q.delete();
        script_q.push_back('{resp: 8'hA5, delay: 10});
        script_q.push_back('{resp: 8'hA5, delay: 10});
        s0 = send_cnt; d0 = done_cnt;
        drive_push(SET_YAW, 16'hAAAA);
        drive_push(SET_YAW, 16'hBBBB);
        drive_idle();
        repeat (4) @(negedge clk);
        check("abort_pre_state", 64'(dbg.state), 64'(ST_WAIT_RESP));
        c0 = clr_cnt;
        @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        check("abort_no_done", 64'(done), 64'd0);
        drive_idle();
        @(negedge clk);
        check("abort_idle", 64'({busy, 3'(dbg.state)}), 64'(ST_IDLE));
        repeat (30) @(negedge clk);
        check("abort_sends", 64'(send_cnt - s0), 64'd1);
        check("abort_dones", 64'(done_cnt - d0), 64'd0);
        check("abort_stale_clr", 64'(clr_cnt - c0), 64'd1);
        check("abort_rdy_drained", 64'({resp_rdy, full}), 64'd0);

        // Queue must be empty after abort: next command is the fresh one.
        script_q.delete();
        script_q.push_back('{resp: 8'hA5, delay: 2});
        exp_q.push_back({MOTORS_OFF, 16'h5555, 1'b1, 2'd1, 8'hA5});
        d0 = done_cnt;
        drive_push(MOTORS_OFF, 16'h5555);
        drive_idle();
        wait_dones(d0 + 1, 200);
        repeat (3) @(negedge clk);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
